// File: rtl/fs_mp_sub_seq.sv
// fs_mp_sub_seq: multi-precision subtract sequencer.
// Computes diff = A - B - bin over WORDS x 32-bit limbs with a single shared
// 32-bit full subtractor. Limbs are processed least significant first, one
// per cycle. The borrow is chained through a register, and the operand and
// result sides use valid/ready handshakes.
//
// Optional feature: define FS_MP_OVF_EN to add the 'ovf' output, which is the
// signed two's-complement overflow of the full-width subtraction.

// 32-bit full subtractor: {bout, diff} = a - b - bin. The flags describe diff.
module fs_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] diff,
  output logic        bout,
  output logic        z,
  output logic        n
);

  logic [32:0] wide;

  // A 33-bit subtraction leaves the borrow in bit 32. The bit is set exactly
  // when a < b + bin, treating a and b as unsigned.
  assign wide = {1'b0, a} - {1'b0, b} - {32'd0, bin};
  assign diff = wide[31:0];
  assign bout = wide[32];
  assign z    = (wide[31:0] == 32'd0);
  assign n    = wide[31];

endmodule

module fs_mp_sub_seq #(
  parameter int WORDS = 4,  // limbs per operand, 1..8
  parameter int CW    = 3   // limb counter width, 2**CW >= WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*WORDS-1:0] a,
  input  logic [32*WORDS-1:0] b,
  input  logic                bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*WORDS-1:0] diff,
  output logic                bout,
  output logic                z,
  output logic                n,
  output logic                busy
`ifdef FS_MP_OVF_EN
  ,
  output logic                ovf
`endif
);

  // The limb index is only as wide as the limb array needs. This keeps the
  // array select exact even when CW is wider.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [WORDS-1:0][31:0] a_q;
  logic [WORDS-1:0][31:0] b_q;
  logic [WORDS-1:0][31:0] diff_q;
  logic [CW-1:0]          cnt;
  logic                   brw_q;
  logic                   zacc_q;

  logic [IW-1:0]          lidx;
  logic                   last;
  logic                   accept;

  logic [31:0]            fs_a;
  logic [31:0]            fs_b;
  logic [31:0]            fs_diff;
  logic                   fs_bout;
  logic                   fs_z;
  logic                   fs_n;

  assign lidx   = cnt[IW-1:0];
  assign last   = (cnt == CW'(WORDS - 1));
  assign accept = in_valid & in_ready;
  assign diff   = diff_q;

  // The shared subtractor always sees the current limb of the latched operands.
  assign fs_a = a_q[lidx];
  assign fs_b = b_q[lidx];

  fs_32bit u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (brw_q),
    .diff (fs_diff),
    .bout (fs_bout),
    .z    (fs_z),
    .n    (fs_n)
  );

  // Capture the operands when they are accepted.
  // NOTE: the operand registers have no reset. They are only read in RUN, and
  // RUN can only be reached through an accept that loads them first.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Sequencer FSM: accept, walk the limbs LSB first, then hold the result
  // until the consumer takes it. All handshake outputs are registered here.
  // NOTE: every state register uses non-blocking assignments, so each branch
  // reads the values from before the edge (for example zacc_q when forming z).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      diff_q    <= '0;
      brw_q     <= 1'b0;
      zacc_q    <= 1'b0;
      bout      <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef FS_MP_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            brw_q    <= bin;
            diff_q   <= '0;
            zacc_q   <= 1'b1;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
          diff_q[lidx] <= fs_diff;
          brw_q        <= fs_bout;
          zacc_q       <= zacc_q & fs_z;
          if (last) begin
            // The top limb sets the flags. The counter goes back to zero here
            // rather than wrapping past WORDS-1.
            cnt       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bout      <= fs_bout;
            n         <= fs_n;
            z         <= zacc_q & fs_z;
`ifdef FS_MP_OVF_EN
            ovf       <= (fs_a[31] != fs_b[31]) & (fs_diff[31] != fs_a[31]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fs_mp_sub_seq.sv
// tb_fs_mp_sub_seq: directed bench for fs_mp_sub_seq with WORDS=4.
// Expected values are hand-computed 128-bit constants.
// The ovf checks are compiled in only when FS_MP_OVF_EN is defined.
module tb_fs_mp_sub_seq;

  localparam int W  = 4;
  localparam int DW = 32 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] diff;
  logic          bout;
  logic          z;
  logic          n;
  logic          busy;
`ifdef FS_MP_OVF_EN
  logic          ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fs_mp_sub_seq #(.WORDS(W), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .z         (z),
    .n         (n),
    .busy      (busy)
`ifdef FS_MP_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand set. Returns the number of edges from acceptance until
  // out_valid is seen (bounded at 20) and the number of cycles busy was high.
  task automatic run_op(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                        input logic bi, output int lat, output int busy_cyc);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~av;  // scramble the ports: the result must come from latched values
    b        = ~bv;
    bin      = ~bi;
    lat      = 0;
    busy_cyc = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cyc++;
      tick();
      lat++;
    end
  endtask

  // Complete the output handshake in one cycle.
  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy, bout, z, n} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 100000", {in_ready, out_valid, busy, bout, z, n});
    end
    n_cmp++;
    if (diff !== '0) begin
      n_bad++;
      $display("FAIL reset_diff: got %h expected 0", diff);
    end
`ifdef FS_MP_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(128'd2, 128'd1, 1'b0, lat, bc);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if (bc !== 4) begin
      n_bad++;
      $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
    end
    n_cmp++;
    if (diff !== 128'd1) begin
      n_bad++;
      $display("FAIL basic_diff: got %h expected 1", diff);
    end
    n_cmp++;
    if ({bout, z, n, in_ready, busy} !== 5'b00000) begin
      n_bad++;
      $display("FAIL basic_flags: got %b expected 00000", {bout, z, n, in_ready, busy});
    end
`ifdef FS_MP_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ovf: got %b expected 0", ovf);
    end
`endif
    handshake();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_release: got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_borrow_chain();
    int lat, bc;
    run_op(128'h00000000_00000000_00000001_00000000, 128'd1, 1'b0, lat, bc);
    n_cmp++;
    if (diff !== 128'h00000000_00000000_00000000_FFFFFFFF) begin
      n_bad++;
      $display("FAIL chain_diff: got %h expected 000000000000000000000000ffffffff", diff);
    end
    n_cmp++;
    if ({bout, z, n} !== 3'b000) begin
      n_bad++;
      $display("FAIL chain_flags: got %b expected 000", {bout, z, n});
    end
    handshake();
  endtask

  task automatic test_bin_all_ones();
    int lat, bc;
    run_op('0, '0, 1'b1, lat, bc);
    n_cmp++;
    if (diff !== {DW{1'b1}}) begin
      n_bad++;
      $display("FAIL binones_diff: got %h expected all ones", diff);
    end
    n_cmp++;
    if ({bout, z, n} !== 3'b101) begin
      n_bad++;
      $display("FAIL binones_flags: got %b expected 101", {bout, z, n});
    end
    handshake();
  endtask

  task automatic test_abort_reset();
    int seen;
    a        = 128'd5;
    b        = 128'd1;
    bin      = 1'b0;
    in_valid = 1'b1;
    tick();  // e0: accepted
    in_valid = 1'b0;
    tick();  // limb 0 written, counter 1
    tick();  // limb 1 written, counter 2
    n_cmp++;
    if (diff !== 128'd4 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_partial: got diff=%h busy=%b expected diff=4 busy=1", diff, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy, bout, z, n} !== 6'b100000 || diff !== '0) begin
      n_bad++;
      $display("FAIL abort_state: got flags=%b diff=%h expected 100000 diff=0",
               {in_ready, out_valid, busy, bout, z, n}, diff);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_equal_zero();
    int lat, bc;
    run_op(128'h12345678_9ABCDEF0_0F0F0F0F_DEADBEEF,
           128'h12345678_9ABCDEF0_0F0F0F0F_DEADBEEF, 1'b0, lat, bc);
    n_cmp++;
    if (diff !== '0) begin
      n_bad++;
      $display("FAIL equal_diff: got %h expected 0", diff);
    end
    n_cmp++;
    if ({bout, z, n} !== 3'b010) begin
      n_bad++;
      $display("FAIL equal_flags: got %b expected 010", {bout, z, n});
    end
    handshake();
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_op({1'b0, {(DW-1){1'b1}}}, {DW{1'b1}}, 1'b0, lat, bc);
    n_cmp++;
    if (diff !== {1'b1, {(DW-1){1'b0}}}) begin
      n_bad++;
      $display("FAIL ovf_diff: got %h expected 800...0", diff);
    end
    n_cmp++;
    if ({bout, z, n} !== 3'b101) begin
      n_bad++;
      $display("FAIL ovf_flags: got %b expected 101", {bout, z, n});
    end
`ifdef FS_MP_OVF_EN
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_bit: got %b expected 1", ovf);
    end
`endif
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    // Result 0xFFFFFFFF_00000000_00000000_00000001 with borrow out.
    run_op(128'd3, 128'h00000001_00000000_00000000_00000002, 1'b0, lat, bc);
    // Hold the result under backpressure while new operands are offered.
    for (int i = 0; i < 3; i++) begin
      a         = 128'd99;
      b         = 128'd7;
      in_valid  = (i != 1);
      out_ready = 1'b0;
      tick();
      n_cmp++;
      if ({out_valid, in_ready, busy, bout, z, n} !== 6'b100101 ||
          diff !== 128'hFFFFFFFF_00000000_00000000_00000001) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got flags=%b diff=%h expected 100101 diff=ffffffff000000000000000000000001",
                 i, {out_valid, in_ready, busy, bout, z, n}, diff);
      end
    end
    in_valid = 1'b0;
    handshake();
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_release: got %b expected 010", {out_valid, in_ready, busy});
    end
    // The next operand set is accepted on the very next edge.
    run_op(128'h00000000_00000005_00000000_00000000, 128'd1, 1'b1, lat, bc);
    n_cmp++;
    if (lat !== 4 || bc !== 4) begin
      n_bad++;
      $display("FAIL b2b_timing: got lat=%0d busy=%0d expected 4 4", lat, bc);
    end
    n_cmp++;
    if (diff !== 128'h00000000_00000004_FFFFFFFF_FFFFFFFE || {bout, z, n} !== 3'b000) begin
      n_bad++;
      $display("FAIL b2b_result: got diff=%h flags=%b expected 0000000000000004fffffffffffffffe 000",
               diff, {bout, z, n});
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_chain();
    test_bin_all_ones();
    test_abort_reset();
    test_equal_zero();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
